trace_port_deserializer: RTL and testbench

// - Parametrised TPIU trace-port front end between the trace pins and the trace capture/matching logic.
// - Successor to the fixed 4-bit TRACEDATA path, which only supported fixed lane mapping and reversal.
// - Runtime-selectable port width of 1/2/4/8 lanes and optional lane reversal.
// - Hunts for the TPIU full sync (bit stream: 31 ones then one zero) and byte-aligns on it.
// - Emits aligned trace bytes with a valid strobe; drives the 'synchronized' status.

---
 rtl/trace_port_deserializer.sv | 182 ++++++++++++++++++
 tb/tb_trace_port_deserializer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_port_deserializer.sv
// TPIU trace-port front end: 1/2/4/8-lane sampling, optional lane reversal, full-sync hunt and byte alignment.
// Optional statistics counters are built when TRACE_DESER_STATS_EN is defined; otherwise they are tied to 0.
module trace_port_deserializer #(
   parameter int pMAX_WIDTH      = 4,
   parameter int pSYNC_CNT_WIDTH = 16
) (
   input  logic                       fe_clk,
   input  logic                       reset,
   input  logic [pMAX_WIDTH-1:0]      trace_data_in,
   input  logic                       I_enable,
   input  logic [1:0]                 I_port_width,
   input  logic                       I_reverse,
   output logic [7:0]                 O_data,
   output logic                       O_data_valid,
   output logic                       synchronized,
   output logic                       O_realign,
   output logic                       O_cfg_err,
   output logic [pSYNC_CNT_WIDTH-1:0] O_sync_count,
   output logic [7:0]                 O_realign_count
);

   localparam int MAX_LOG2 = $clog2(pMAX_WIDTH);

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t                state, state_nxt;
   logic [pMAX_WIDTH-1:0] sample_p0;
   logic [7:0]            raw8, mapped, lane_mask;
   logic [3:0]            n_lanes;
   logic [5:0]            ones_cnt, ones_nxt;
   logic [6:0]            ones_sum;
   logic [3:0]            bit_ptr, ptr_nxt, ptr_sum;
   logic [7:0]            shift_p1, shift_nxt, shift_shifted;
   logic [1:0]            width_q;
   logic                  rev_q;
   logic                  all_ones, sync_hit, abort, byte_done;
   logic                  emit, realign_nxt;

   // Lane i is swapped with lane n-1-i; lanes at or above n read as zero.
   function automatic logic [7:0] map_lanes(input logic [7:0] raw, input logic [3:0] n, input logic rev);
      logic [7:0] m;
      logic [2:0] idx;
      m = '0;
      for (int i = 0; i < 8; i++) begin
         if (4'(i) < n) begin
            idx       = rev ? 3'(n - 4'd1 - 4'(i)) : 3'(i);
            m[3'(i)]  = raw[idx];
         end
      end
      return m;
   endfunction

   assign O_cfg_err    = (I_port_width > 2'(MAX_LOG2));
   assign synchronized = (state == LOCKED);

   // Stage p0: pins registered once
   always_ff @(posedge fe_clk or posedge reset) begin
      if (reset) sample_p0 <= '0;
      else       sample_p0 <= trace_data_in;
   end

   always_comb begin
      n_lanes   = 4'd1;
      lane_mask = 8'h01;
      case (I_port_width)
         2'd0: begin n_lanes = 4'd1; lane_mask = 8'h01; end
         2'd1: begin n_lanes = 4'd2; lane_mask = 8'h03; end
         2'd2: begin n_lanes = 4'd4; lane_mask = 8'h0F; end
         2'd3: begin n_lanes = 4'd8; lane_mask = 8'hFF; end
         default: begin n_lanes = 4'd1; lane_mask = 8'h01; end
      endcase
   end

   assign raw8          = 8'(sample_p0);
   assign mapped        = map_lanes(raw8, n_lanes, I_reverse);
   assign all_ones      = (mapped == lane_mask);
   assign sync_hit      = (mapped == (lane_mask >> 1)) && !O_cfg_err &&
                          (7'(ones_cnt) >= (7'd32 - 7'(n_lanes)));
   assign abort         = !I_enable || O_cfg_err || (I_port_width != width_q) || (I_reverse != rev_q);
   assign ones_sum      = 7'(ones_cnt) + 7'(n_lanes);
   assign ptr_sum       = bit_ptr + n_lanes;
   assign byte_done     = (ptr_sum == 4'd8);
   // New lanes enter at the top so the earliest sample ends up in the byte LSBs.
   assign shift_shifted = (shift_p1 >> n_lanes) | (mapped << (4'd8 - n_lanes));

   always_ff @(posedge fe_clk or posedge reset) begin
      if (reset) state <= HUNT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = HUNT;
      end else begin
         case (state)
            HUNT:    if (sync_hit) state_nxt = LOCKED;
            LOCKED:  state_nxt = LOCKED;
            default: state_nxt = HUNT;
         endcase
      end
   end

   always_comb begin
      ones_nxt    = all_ones ? ((ones_sum > 7'd63) ? 6'd63 : ones_sum[5:0]) : 6'd0;
      ptr_nxt     = bit_ptr;
      shift_nxt   = shift_shifted;
      emit        = 1'b0;
      realign_nxt = 1'b0;
      if (abort) begin
         ones_nxt  = 6'd0;
         ptr_nxt   = 4'd0;
         shift_nxt = '0;
      end else begin
         case (state)
            HUNT: begin
               ptr_nxt = 4'd0;
               if (sync_hit) shift_nxt = '0;
            end
            LOCKED: begin
               ptr_nxt = ptr_sum;
               if (byte_done) begin
                  emit    = 1'b1;
                  ptr_nxt = 4'd0;
               end else if (sync_hit) begin
                  realign_nxt = 1'b1;
                  ptr_nxt     = 4'd0;
                  shift_nxt   = '0;
               end
            end
            default: ptr_nxt = 4'd0;
         endcase
      end
   end

   // Stage p1: byte assembly and aligned output
   always_ff @(posedge fe_clk or posedge reset) begin
      if (reset) begin
         ones_cnt     <= '0;
         bit_ptr      <= '0;
         width_q      <= '0;
         rev_q        <= 1'b0;
         O_data       <= '0;
         O_data_valid <= 1'b0;
         O_realign    <= 1'b0;
      end else begin
         ones_cnt     <= ones_nxt;
         bit_ptr      <= ptr_nxt;
         width_q      <= I_port_width;
         rev_q        <= I_reverse;
         O_data_valid <= emit;
         O_realign    <= realign_nxt;
         if (emit) O_data <= shift_nxt;
      end
   end

   always_ff @(posedge fe_clk) begin
      shift_p1 <= shift_nxt;
   end

`ifdef TRACE_DESER_STATS_EN
   logic [pSYNC_CNT_WIDTH-1:0] sync_cnt;
   logic [7:0]                 realign_cnt;

   always_ff @(posedge fe_clk or posedge reset) begin
      if (reset) begin
         sync_cnt    <= '0;
         realign_cnt <= '0;
      end else begin
         if (sync_hit && !(&sync_cnt))         sync_cnt    <= sync_cnt + pSYNC_CNT_WIDTH'(1);
         if (realign_nxt && realign_cnt != 8'hFF) realign_cnt <= realign_cnt + 8'd1;
      end
   end

   assign O_sync_count    = sync_cnt;
   assign O_realign_count = realign_cnt;
`else
   assign O_sync_count    = '0;
   assign O_realign_count = '0;
`endif

endmodule

// File: tb/tb_trace_port_deserializer.sv
// Directed bench for trace_port_deserializer: sync hunt, lane widths, reversal, realign, mode change, errors, reset.
module tb_trace_port_deserializer;

   logic        fe_clk;
   logic        reset;
   logic [3:0]  trace_data_in;
   logic        I_enable;
   logic [1:0]  I_port_width;
   logic        I_reverse;
   logic [7:0]  O_data;
   logic        O_data_valid;
   logic        synchronized;
   logic        O_realign;
   logic        O_cfg_err;
   logic [15:0] O_sync_count;
   logic [7:0]  O_realign_count;

   int          n_checks;
   int          n_fail;
   logic [7:0]  got_q[$];
   int          realign_seen;

   trace_port_deserializer #(.pMAX_WIDTH(4), .pSYNC_CNT_WIDTH(16)) dut (
      .fe_clk          (fe_clk),
      .reset           (reset),
      .trace_data_in   (trace_data_in),
      .I_enable        (I_enable),
      .I_port_width    (I_port_width),
      .I_reverse       (I_reverse),
      .O_data          (O_data),
      .O_data_valid    (O_data_valid),
      .synchronized    (synchronized),
      .O_realign       (O_realign),
      .O_cfg_err       (O_cfg_err),
      .O_sync_count    (O_sync_count),
      .O_realign_count (O_realign_count)
   );

   initial fe_clk = 1'b0;
   always #5 fe_clk = ~fe_clk;

   always @(negedge fe_clk) begin
      if (!reset) begin
         if (O_data_valid) got_q.push_back(O_data);
         if (O_realign)    realign_seen++;
      end
   end

   task automatic drive(input logic [3:0] v);
      trace_data_in = v;
      @(posedge fe_clk);
      #1;
   endtask

   task automatic setup(input logic [1:0] pw, input logic rev);
      I_enable     = 1'b0;
      I_port_width = pw;
      I_reverse    = rev;
      drive(4'h0);
      drive(4'h0);
      I_enable = 1'b1;
      drive(4'h0);
      got_q.delete();
      realign_seen = 0;
   endtask

   task automatic wind_down();
      I_enable = 1'b0;
      drive(4'h0);
      drive(4'h0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      I_enable = 1'b0;
      I_port_width = 2'd2;
      I_reverse = 1'b0;
      trace_data_in = 4'hF;
      repeat (3) @(posedge fe_clk);
      #1;
      n_checks++;
      if ({O_data, O_data_valid, synchronized, O_realign, O_cfg_err} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 000", {O_data, O_data_valid, synchronized, O_realign, O_cfg_err});
      end
      n_checks++;
      if ({O_sync_count, O_realign_count} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_counts: got %h required 000000", {O_sync_count, O_realign_count});
      end
      reset = 1'b0;
      drive(4'h0);
   endtask

   task automatic test_4lane();
      setup(2'd2, 1'b0);
      repeat (7) drive(4'hF);
      drive(4'h7);
      n_checks++;
      if (synchronized !== 1'b0) begin
         n_fail++;
         $display("FAIL lane4_lock_early: got %b required 0", synchronized);
      end
      drive(4'h3);
      n_checks++;
      if (synchronized !== 1'b1) begin
         n_fail++;
         $display("FAIL lane4_lock: got %b required 1", synchronized);
      end
      drive(4'hA);
      n_checks++;
      if (O_data_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL lane4_valid_early: got %b required 0", O_data_valid);
      end
      drive(4'h0);
      n_checks++;
      if ({O_data_valid, O_data} !== {1'b1, 8'hA3}) begin
         n_fail++;
         $display("FAIL lane4_byte: got valid=%b data=%h required valid=1 data=a3", O_data_valid, O_data);
      end
      wind_down();
      n_checks++;
      if (got_q.size() != 1) begin
         n_fail++;
         $display("FAIL lane4_pulses: got %0d required 1", got_q.size());
      end
      n_checks++;
      if (synchronized !== 1'b0) begin
         n_fail++;
         $display("FAIL lane4_disable: got %b required 0", synchronized);
      end
   endtask

   task automatic test_1lane();
      logic [7:0] bits;
      bits = 8'h8D;
      setup(2'd0, 1'b0);
      repeat (31) drive(4'b1011);
      drive(4'b0110);
      for (int i = 0; i < 8; i++) drive({3'b101, bits[i]});
      drive(4'h0);
      n_checks++;
      if ({O_data_valid, O_data} !== {1'b1, 8'h8D}) begin
         n_fail++;
         $display("FAIL lane1_byte: got valid=%b data=%h required valid=1 data=8d", O_data_valid, O_data);
      end
      wind_down();
      n_checks++;
      if (got_q.size() != 1) begin
         n_fail++;
         $display("FAIL lane1_pulses: got %0d required 1", got_q.size());
      end
   endtask

   task automatic test_reverse();
      setup(2'd2, 1'b1);
      repeat (7) drive(4'hF);
      drive(4'hE);
      drive(4'hC);
      n_checks++;
      if (synchronized !== 1'b1) begin
         n_fail++;
         $display("FAIL rev_lock: got %b required 1", synchronized);
      end
      drive(4'h5);
      drive(4'h0);
      n_checks++;
      if ({O_data_valid, O_data} !== {1'b1, 8'hA3}) begin
         n_fail++;
         $display("FAIL rev_byte: got valid=%b data=%h required valid=1 data=a3", O_data_valid, O_data);
      end
      wind_down();
      n_checks++;
      if (got_q.size() != 1) begin
         n_fail++;
         $display("FAIL rev_pulses: got %0d required 1", got_q.size());
      end
   endtask

   task automatic test_realign();
      logic [7:0] exp_bytes[6];
      logic [7:0] exp_rc;
      exp_bytes = '{8'h39, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'hD2};
`ifdef TRACE_DESER_STATS_EN
      exp_rc = 8'd1;
`else
      exp_rc = 8'd0;
`endif
      setup(2'd1, 1'b0);
      repeat (15) drive(4'h3);
      drive(4'h1);
      drive(4'h1);
      n_checks++;
      if (synchronized !== 1'b1) begin
         n_fail++;
         $display("FAIL realign_lock: got %b required 1", synchronized);
      end
      drive(4'h2);
      drive(4'h3);
      drive(4'h0);
      drive(4'h0);
      repeat (15) drive(4'h3);
      drive(4'h1);
      drive(4'h2);
      n_checks++;
      if ({O_realign, O_data_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL realign_pulse: got realign=%b valid=%b required realign=1 valid=0", O_realign, O_data_valid);
      end
      drive(4'h0);
      drive(4'h1);
      drive(4'h3);
      drive(4'h0);
      wind_down();
      n_checks++;
      if (got_q.size() != 6) begin
         n_fail++;
         $display("FAIL realign_pulses: got %0d required 6", got_q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got_q[i] !== exp_bytes[i]) begin
               n_fail++;
               $display("FAIL realign_byte%0d: got %h required %h", i, got_q[i], exp_bytes[i]);
            end
         end
      end
      n_checks++;
      if (realign_seen != 1) begin
         n_fail++;
         $display("FAIL realign_count_seen: got %0d required 1", realign_seen);
      end
      n_checks++;
      if (O_realign_count !== exp_rc) begin
         n_fail++;
         $display("FAIL realign_count_port: got %0d required %0d", O_realign_count, exp_rc);
      end
   endtask

   task automatic test_mode_change();
      setup(2'd2, 1'b0);
      repeat (7) drive(4'hF);
      drive(4'h7);
      drive(4'h3);
      I_port_width = 2'd1;
      drive(4'hA);
      n_checks++;
      if (synchronized !== 1'b0) begin
         n_fail++;
         $display("FAIL mode_unlock: got %b required 0", synchronized);
      end
      repeat (4) drive(4'h2);
      n_checks++;
      if (got_q.size() != 0) begin
         n_fail++;
         $display("FAIL mode_no_valid: got %0d pulses required 0", got_q.size());
      end
      repeat (15) drive(4'h3);
      drive(4'h1);
      drive(4'h3);
      drive(4'h3);
      drive(4'h0);
      drive(4'h0);
      drive(4'h0);
      wind_down();
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== 8'h0F) begin
         n_fail++;
         $display("FAIL mode_relock_byte: got %0d pulses first=%h required 1 pulse 0f",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
      end
   endtask

   task automatic test_cfg_err();
      logic locked_any;
      locked_any = 1'b0;
      setup(2'd3, 1'b0);
      n_checks++;
      if (O_cfg_err !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg_err_set: got %b required 1", O_cfg_err);
      end
      for (int i = 0; i < 12; i++) begin
         drive(4'hF);
         locked_any |= synchronized;
      end
      drive(4'h7);
      for (int i = 0; i < 6; i++) begin
         drive(4'h3);
         locked_any |= synchronized;
      end
      n_checks++;
      if (locked_any !== 1'b0 || got_q.size() != 0) begin
         n_fail++;
         $display("FAIL cfg_err_nolock: got locked=%b pulses=%0d required 0 0", locked_any, got_q.size());
      end
      I_port_width = 2'd2;
      #1;
      n_checks++;
      if (O_cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_err_clear: got %b required 0", O_cfg_err);
      end
      wind_down();
   endtask

   task automatic test_reset_mid_byte();
      setup(2'd2, 1'b0);
      repeat (7) drive(4'hF);
      drive(4'h7);
      drive(4'h3);
      #1;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({O_data, O_data_valid, synchronized, O_realign} !== 11'h000) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got data=%h valid=%b sync=%b realign=%b required all 0",
                  O_data, O_data_valid, synchronized, O_realign);
      end
      n_checks++;
      if (O_realign_count !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_mid_realign_count: got %0d required 0", O_realign_count);
      end
      @(posedge fe_clk);
      #1;
      reset = 1'b0;
      setup(2'd2, 1'b0);
      repeat (7) drive(4'hF);
      drive(4'h7);
      drive(4'hC);
      drive(4'h5);
      drive(4'h0);
      wind_down();
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== 8'h5C) begin
         n_fail++;
         $display("FAIL reset_mid_relock: got %0d pulses first=%h required 1 pulse 5c",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
      end
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      realign_seen = 0;
      test_reset();
      test_4lane();
      test_1lane();
      test_reverse();
      test_realign();
      test_mode_change();
      test_cfg_err();
      test_reset_mid_byte();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
